softmax_result_reader: RTL and testbench
========================================

# softmax_result_reader

Sequential consumer of the softmax layer's probability vector. It captures one N-word vector through a valid/ready handshake, then scans it one element per cycle. From the scan it produces the top-1 class index, the winning probability, a confidence flag and a sum-sanity flag. It sits directly after the softmax layer and feeds the classification result to downstream control logic.

## Interface
- N, 10, number of classes (vector length), N >= 2
- WIDTH, 16, signed input word width
- NFRAC, 10, fractional bits of input words (1.0 = 2**NFRAC)
- THRESH, 512, confidence threshold in input format (0.5 at NFRAC=10)
- SUM_TOL, 64, allowed |sum - 2**NFRAC| before sum_err is raised
- IDXW, $clog2(N), class index width (derived, localparam)
- SUMW, WIDTH+$clog2(N), sum accumulator width (derived, localparam)

- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- dataIn  in  signed [WIDTH-1:0] x N (unpacked [N-1:0])  probability vector
- in_valid  in  1  dataIn is valid
- in_ready  out  1  block can accept a vector
- class_idx  out  IDXW  argmax index
- class_val  out  signed WIDTH  value at class_idx
- exp_sum  out  signed SUMW  sum of all N elements
- confident  out  1  class_val >= THRESH
- sum_err  out  1  |exp_sum - 2**NFRAC| > SUM_TOL
- out_valid  out  1  result fields valid
- out_ready  in  1  downstream accepts result

## Operation
- FSM has three states.
- IDLE: in_ready=1. On in_valid, all N words are registered into a capture buffer, idx<=0, max_val<=most-negative WIDTH value, max_idx<=0, acc<=0. Next state is SCAN.
- SCAN: in_ready=0. Each cycle processes buf[idx]:
  - acc += sign-extended buf[idx].
  - If buf[idx] > max_val (signed, strict), max_val/max_idx are updated. Ties therefore resolve to the lowest index.
  - At idx==N-1, the final values are committed to the output registers and the next state is DONE. Otherwise idx++.
- DONE: out_valid=1, all result outputs stable. When out_valid && out_ready, the next state is IDLE.
- confident and sum_err are computed from the final max/sum and registered with the other results.
- Arithmetic: accumulation is in SUMW bits and cannot overflow. The |sum - 2**NFRAC| comparison is done in SUMW+1 bits.
- Negative inputs are legal and treated as signed. An all-negative vector yields its least-negative element.
- in_valid while in_ready=0 is ignored. The capture buffer is not modified during SCAN or DONE.

## Timing
- Reset values: in_ready=1, out_valid=0, class_idx=0, class_val=0, exp_sum=0, confident=0, sum_err=0, FSM=IDLE, idx=0.
- Latency: a vector accepted at edge E gives out_valid=1 after edge E+N, i.e. N cycles in SCAN and the first DONE cycle at E+N.
- Minimum vector period is N+2 cycles (IDLE, N×SCAN, DONE) when out_ready is held high.
- in_ready returns to 1 the cycle after the output handshake.
- Backpressure: out_ready low holds DONE indefinitely, with all outputs bit-stable.
- Result outputs keep their last values after the handshake, but out_valid drops.
- Reset mid-SCAN or in DONE: the next cycle is IDLE with all outputs at their reset values. The partial result is discarded.
- Reset has priority over any simultaneous handshake.

## Structure
- Shared package `softmax_pkg`: typedef `rdr_state_t` {IDLE, SCAN, DONE}, default THRESH/SUM_TOL constants, and a width helper for SUMW.
- One sub-module `argmax_scan_step`, a combinational compare/accumulate step with these ports:
  - inputs: current element, index, running max, max index, accumulator.
  - outputs: next max, next max index, next accumulator.
- The FSM, capture buffer and output registers are in the top module.

## Test plan
- N=4, THRESH=512, SUM_TOL=64 for all scenarios.
- {256,256,256,256} -> class_idx=0, class_val=256, exp_sum=1024, confident=0, sum_err=0; out_valid 4 cycles after acceptance.
- {100,900,20,4} -> class_idx=1, class_val=900, exp_sum=1024, confident=1, sum_err=0.
- {-5,-3,-1,-7} -> class_idx=2, class_val=-1, exp_sum=-16, confident=0, sum_err=1.
- Second vector {0,0,600,600} with out_ready low for 5 cycles in DONE -> outputs stable, in_ready=0 throughout; after release class_idx=2, class_val=600, exp_sum=1200, sum_err=1 (176 > 64).
- Reset pulsed on the 2nd SCAN cycle -> next cycle out_valid=0, in_ready=1, outputs 0; a following vector {0,0,0,1024} gives class_idx=3, confident=1.
- in_valid and out_ready held high with changing vectors -> one acceptance every 6 cycles; the bench checks every result against a reference model.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax result reader.
package softmax_pkg;

  // Reader FSM: capture a vector, scan it element by element, then hold the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } rdr_state_t;

  // 0.5 in Q.10
  localparam int DEFAULT_THRESH  = 512;
  // Allowed deviation of the probability sum from 1.0
  localparam int DEFAULT_SUM_TOL = 64;

  // Accumulator width that cannot overflow when summing n words of the given width.
  function automatic int sum_width(input int width, input int n);
    return width + $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_scan_step.sv
// One combinational step of the argmax/sum scan: folds a single element into
// the running maximum and the running sum.
module argmax_scan_step #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 4,
  parameter int SUMW  = 20
) (
  input  logic signed [WIDTH-1:0] elem,
  input  logic        [IDXW-1:0]  elem_idx,
  input  logic signed [WIDTH-1:0] max_val,
  input  logic        [IDXW-1:0]  max_idx,
  input  logic signed [SUMW-1:0]  acc,
  output logic signed [WIDTH-1:0] max_val_next,
  output logic        [IDXW-1:0]  max_idx_next,
  output logic signed [SUMW-1:0]  acc_next
);

  logic signed [SUMW-1:0] elem_ext;

  assign elem_ext = {{(SUMW-WIDTH){elem[WIDTH-1]}}, elem};

  // Strict greater-than keeps the earliest index on ties.
  always_comb begin
    max_val_next = max_val;
    max_idx_next = max_idx;
    if (elem > max_val) begin
      max_val_next = elem;
      max_idx_next = elem_idx;
    end
    acc_next = acc + elem_ext;
  end

endmodule

// File: rtl/softmax_result_reader.sv
// Captures one softmax probability vector, scans it one element per cycle and
// presents the top-1 class, its probability, the total and two sanity flags.
module softmax_result_reader
  import softmax_pkg::*;
#(
  parameter int N       = 10,
  parameter int WIDTH   = 16,
  parameter int NFRAC   = 10,
  parameter int THRESH  = DEFAULT_THRESH,
  parameter int SUM_TOL = DEFAULT_SUM_TOL,
  localparam int IDXW   = $clog2(N),
  localparam int SUMW   = sum_width(WIDTH, N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] dataIn [N-1:0],
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic        [IDXW-1:0]  class_idx,
  output logic signed [WIDTH-1:0] class_val,
  output logic signed [SUMW-1:0]  exp_sum,
  output logic                    confident,
  output logic                    sum_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic        [IDXW-1:0]  LAST_IDX = IDXW'(N - 1);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] THRESH_Q = WIDTH'(THRESH);
  localparam logic signed [SUMW:0]    ONE_Q    = (SUMW+1)'(1 << NFRAC);
  localparam logic signed [SUMW:0]    TOL_Q    = (SUMW+1)'(SUM_TOL);

  rdr_state_t              state_reg;
  logic signed [WIDTH-1:0] cap_reg [N-1:0];
  logic        [IDXW-1:0]  idx_reg;
  logic signed [WIDTH-1:0] max_val_reg;
  logic        [IDXW-1:0]  max_idx_reg;
  logic signed [SUMW-1:0]  acc_reg;

  logic                    in_ready_reg;
  logic                    out_valid_reg;
  logic        [IDXW-1:0]  class_idx_reg;
  logic signed [WIDTH-1:0] class_val_reg;
  logic signed [SUMW-1:0]  exp_sum_reg;
  logic                    confident_reg;
  logic                    sum_err_reg;

  logic                    capture_en;
  logic signed [WIDTH-1:0] cur_elem;
  logic signed [WIDTH-1:0] max_val_next;
  logic        [IDXW-1:0]  max_idx_next;
  logic signed [SUMW-1:0]  acc_next;
  logic signed [SUMW:0]    sum_dev;
  logic signed [SUMW:0]    sum_abs;
  logic                    confident_next;
  logic                    sum_err_next;

  // The buffer only loads on an accepted vector, so it is frozen during SCAN/DONE.
  assign capture_en = !reset && (state_reg == IDLE) && in_valid;

  for (genvar gi = 0; gi < N; gi++) begin : g_cap
    // Capture word gi of the incoming vector on acceptance.
    always_ff @(posedge clk) begin
      if (capture_en) begin
        cap_reg[gi] <= dataIn[gi];
      end
    end
  end

  assign cur_elem = cap_reg[idx_reg];

  argmax_scan_step #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW),
    .SUMW  (SUMW)
  ) u_step (
    .elem         (cur_elem),
    .elem_idx     (idx_reg),
    .max_val      (max_val_reg),
    .max_idx      (max_idx_reg),
    .acc          (acc_reg),
    .max_val_next (max_val_next),
    .max_idx_next (max_idx_next),
    .acc_next     (acc_next)
  );

  // Flags derived from the final step; the sign-extended difference cannot wrap.
  always_comb begin
    sum_dev        = $signed({acc_next[SUMW-1], acc_next}) - ONE_Q;
    sum_abs        = sum_dev[SUMW] ? -sum_dev : sum_dev;
    sum_err_next   = (sum_abs > TOL_Q);
    confident_next = (max_val_next >= THRESH_Q);
  end

  // Reader FSM with scan state and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      max_val_reg   <= MOST_NEG;
      max_idx_reg   <= '0;
      acc_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      class_idx_reg <= '0;
      class_val_reg <= '0;
      exp_sum_reg   <= '0;
      confident_reg <= 1'b0;
      sum_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            idx_reg      <= '0;
            max_val_reg  <= MOST_NEG;
            max_idx_reg  <= '0;
            acc_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= SCAN;
          end
        end
        SCAN: begin
          max_val_reg <= max_val_next;
          max_idx_reg <= max_idx_next;
          acc_reg     <= acc_next;
          if (idx_reg == LAST_IDX) begin
            class_idx_reg <= max_idx_next;
            class_val_reg <= max_val_next;
            exp_sum_reg   <= acc_next;
            confident_reg <= confident_next;
            sum_err_reg   <= sum_err_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            idx_reg       <= '0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign class_idx = class_idx_reg;
  assign class_val = class_val_reg;
  assign exp_sum   = exp_sum_reg;
  assign confident = confident_reg;
  assign sum_err   = sum_err_reg;

endmodule

// File: tb/tb_softmax_result_reader.sv
// Directed bench for softmax_result_reader with N=4.
module tb_softmax_result_reader;

  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int IDXW  = 2;
  localparam int SUMW  = 18;

  logic                    clk;
  logic                    reset;
  logic signed [WIDTH-1:0] din [N-1:0];
  logic                    in_valid;
  logic                    in_ready;
  logic        [IDXW-1:0]  class_idx;
  logic signed [WIDTH-1:0] class_val;
  logic signed [SUMW-1:0]  exp_sum;
  logic                    confident;
  logic                    sum_err;
  logic                    out_valid;
  logic                    out_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  softmax_result_reader #(
    .N       (N),
    .WIDTH   (WIDTH),
    .NFRAC   (10),
    .THRESH  (512),
    .SUM_TOL (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dataIn    (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .class_idx (class_idx),
    .class_val (class_val),
    .exp_sum   (exp_sum),
    .confident (confident),
    .sum_err   (sum_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; outputs are sampled and inputs driven there.
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_vec(input int a, input int b, input int c, input int d);
    din[0] = WIDTH'(a);
    din[1] = WIDTH'(b);
    din[2] = WIDTH'(c);
    din[3] = WIDTH'(d);
  endtask

  task automatic chk_result(input string tag, input int e_idx, input int e_val,
                            input int e_sum, input int e_conf, input int e_err);
    chk({tag, ".idx"},  class_idx, e_idx);
    chk({tag, ".val"},  class_val, e_val);
    chk({tag, ".sum"},  exp_sum,   e_sum);
    chk({tag, ".conf"}, confident, e_conf);
    chk({tag, ".err"},  sum_err,   e_err);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"},  in_ready,  1);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk_result(tag, 0, 0, 0, 0, 0);
  endtask

  // Accept one vector, check the N-cycle latency, optionally hold backpressure, then handshake.
  task automatic run_vec(input string tag, input int a, input int b, input int c, input int d,
                         input int e_idx, input int e_val, input int e_sum,
                         input int e_conf, input int e_err, input int hold);
    set_vec(a, b, c, d);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    chk({tag, ".accept_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk({tag, ".scan_valid"}, out_valid, 0);
      chk({tag, ".scan_ready"}, in_ready, 0);
      tick();
    end
    chk({tag, ".latency"}, out_valid, 1);
    chk_result(tag, e_idx, e_val, e_sum, e_conf, e_err);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      set_vec(7, 7, 7, 7);
      tick();
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_ready"}, in_ready, 0);
      chk_result({tag, ".hold"}, e_idx, e_val, e_sum, e_conf, e_err);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, out_valid, 0);
    chk({tag, ".post_ready"}, in_ready, 1);
    chk_result({tag, ".post"}, e_idx, e_val, e_sum, e_conf, e_err);
  endtask

  int vtab [0:4][0:3] = '{
    '{10, 20, 30, 40},
    '{500, -200, 500, 300},
    '{-32768, -32768, -32768, -32768},
    '{1000, 24, 0, 0},
    '{32767, -1, 5, 1}
  };

  initial begin
    int m_idx, m_val, m_sum, m_conf, m_err, dev, last_acc, waited;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_vec(0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    chk_reset_outputs("reset");

    run_vec("uniform", 256, 256, 256, 256, 0, 256, 1024, 0, 0, 0);
    run_vec("peak",    100, 900, 20, 4,    1, 900, 1024, 1, 0, 0);
    run_vec("neg",     -5, -3, -1, -7,     2, -1,  -16,  0, 1, 0);
    run_vec("bp",      0, 0, 600, 600,     2, 600, 1200, 1, 1, 5);

    // Reset during the second SCAN cycle discards the partial result.
    set_vec(1, 2, 3, 4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_outputs("midscan_rst");
    run_vec("after_rst", 0, 0, 0, 1024, 3, 1024, 1024, 1, 0, 0);

    // Streaming with in_valid and out_ready held high; results checked against a model.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    last_acc  = 0;
    for (int i = 0; i < 5; i++) begin
      waited = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
        tick();
        waited++;
      end
      chk("stream.ready_timeout", (waited < 20) ? 1 : 0, 1);
      set_vec(vtab[i][0], vtab[i][1], vtab[i][2], vtab[i][3]);
      if (i > 0) chk("stream.period", cyc - last_acc, 6);
      last_acc = cyc;
      m_idx = 0;
      m_val = -32768;
      m_sum = 0;
      for (int j = 0; j < N; j++) begin
        m_sum += vtab[i][j];
        if (vtab[i][j] > m_val) begin
          m_val = vtab[i][j];
          m_idx = j;
        end
      end
      m_conf = (m_val >= 512) ? 1 : 0;
      dev    = m_sum - 1024;
      if (dev < 0) dev = -dev;
      m_err  = (dev > 64) ? 1 : 0;
      tick();
      waited = 0;
      while (out_valid !== 1'b1 && waited < 20) begin
        tick();
        waited++;
      end
      chk("stream.valid_timeout", (waited < 20) ? 1 : 0, 1);
      chk_result($sformatf("stream%0d", i), m_idx, m_val, m_sum, m_conf, m_err);
    end
    in_valid = 1'b0;
    tick();
    chk("stream.end_valid", out_valid, 0);
    chk("stream.end_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
